// File: rtl/crossbar_slave_mem_pkg.sv
// Shared types and helpers for the crossbar slave-side memory.
package crossbar_slave_mem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 31;

  // Handshake FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Word index of a byte address: drop the byte offset and keep only the
  // low depth_log2 word bits, so addresses above the array alias onto it.
  function automatic logic [ADDR_WIDTH-3:0] word_index(
    input logic [ADDR_WIDTH-1:0] addr,
    input int unsigned           depth_log2
  );
    logic [ADDR_WIDTH-3:0] mask;
    mask = ~({(ADDR_WIDTH-2){1'b1}} << depth_log2);
    return addr[ADDR_WIDTH-1:2] & mask;
  endfunction

endpackage

// File: rtl/crossbar_slave_mem_ram.sv
// Single-port synchronous RAM, read-first, registered read data, no reset.
module crossbar_slave_mem_ram
  import crossbar_slave_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] index_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array write and registered read of the addressed word
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
    rdata_q <= mem_q[index_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/crossbar_slave_mem.sv
// Crossbar slave port terminator: captures a request, waits a fixed number
// of cycles, acks, and presents read data in the cycle after the ack.
module crossbar_slave_mem
  import crossbar_slave_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  cmd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  // Counter start value; with no wait states the counter is never consulted.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  capture;

  // Request fields latched on acceptance; held for the whole transaction.
  logic                  cmd_q;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign capture = (state_q == IDLE) && req;
  assign idx_d   = DEPTH_LOG2'(word_index(addr, DEPTH_LOG2));

  // State and wait counter, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the accepted request; inputs are ignored until the next IDLE
  always_ff @(posedge clock) begin
    if (capture) begin
      cmd_q   <= cmd;
      idx_q   <= idx_d;
      wdata_q <= wdata;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WAIT_STATES > 0) ? WAIT : ACK;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; rdata is zero outside the
  // post-read DONE cycle so the crossbar can OR/capture it freely.
  always_comb begin
    ack    = (state_q == ACK);
    busy   = (state_q != IDLE);
    ram_we = (state_q == ACK) && cmd_q;
    rdata  = '0;
    if ((state_q == DONE) && !cmd_q) begin
      rdata = ram_rdata;
    end
  end

  crossbar_slave_mem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clock_i (clock),
    .we_i    (ram_we),
    .index_i (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_crossbar_slave_mem.sv
// Bench for crossbar_slave_mem: two instances (2 and 0 wait states) against
// a transaction-level model of the handshake timing and memory contents.
module tb_crossbar_slave_mem;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_s   [2];
  logic        cmd_s   [2];
  logic [30:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ack_s   [2];
  logic [31:0] rdata_s [2];
  logic        busy_s  [2];

  always #5 clock = ~clock;

  crossbar_slave_mem #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut_ws2 (
    .clock(clock), .reset_n(reset_n), .req(req_s[0]), .cmd(cmd_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]),
    .busy(busy_s[0])
  );

  crossbar_slave_mem #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_ws0 (
    .clock(clock), .reset_n(reset_n), .req(req_s[1]), .cmd(cmd_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]),
    .busy(busy_s[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: per instance, the cycle numbers at which the accepted
  // transaction acks / stops being busy / shows read data, plus the memory.
  int          ack_at  [2];
  int          busy_to [2];
  int          rd_at   [2];
  logic [31:0] rd_val  [2];
  bit          rd_known[2];
  bit          m_cmd   [2];
  int          m_idx   [2];
  logic [31:0] m_wd    [2];
  logic [31:0] mmem    [2][256];
  bit          known   [2][256];

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      ack_at[i]  = -10;
      busy_to[i] = -10;
      rd_at[i]   = -10;
    end
  endtask

  // Compare this cycle's outputs and retire the ACK-cycle memory effect
  task automatic check_cycle(input int i);
    string sfx;
    sfx = $sformatf("[ws%0d]", ws_of(i));
    chk({"ack", sfx}, 32'(ack_s[i]), 32'(cyc == ack_at[i]));
    chk({"busy", sfx}, 32'(busy_s[i]), 32'(cyc > busy_to[i] - (ws_of(i) + 2) && cyc <= busy_to[i]));
    if (cyc == rd_at[i]) begin
      if (rd_known[i]) chk({"rdata", sfx}, rdata_s[i], rd_val[i]);
    end else begin
      chk({"rdata_zero", sfx}, rdata_s[i], 32'h0);
    end
    if (cyc == ack_at[i]) begin
      if (m_cmd[i]) begin
        mmem[i][m_idx[i]]  = m_wd[i];
        known[i][m_idx[i]] = 1'b1;
      end else begin
        rd_val[i]   = mmem[i][m_idx[i]];
        rd_known[i] = known[i][m_idx[i]];
        rd_at[i]    = cyc + 1;
      end
    end
  endtask

  // One clock: check outputs, accept requests per the model, advance
  task automatic step();
    for (int i = 0; i < 2; i++) check_cycle(i);
    for (int i = 0; i < 2; i++) begin
      if (reset_n && req_s[i] && cyc > busy_to[i]) begin
        m_cmd[i]   = cmd_s[i];
        m_idx[i]   = int'((addr_s[i] >> 2) % 256);
        m_wd[i]    = wdata_s[i];
        ack_at[i]  = cyc + 1 + ws_of(i);
        busy_to[i] = cyc + 2 + ws_of(i);
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; cmd_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
    end
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 40 && cyc <= busy_to[i]; k++) step();
  endtask

  // Complete one transaction on instance i, inputs idle afterwards
  task automatic txn(input int i, input bit c, input logic [30:0] a, input logic [31:0] w);
    wait_idle(i);
    req_s[i] = 1'b1; cmd_s[i] = c; addr_s[i] = a; wdata_s[i] = w;
    step();
    idle_inputs();
    wait_idle(i);
    step();
  endtask

  // Asynchronous reset asserted mid-cycle, outputs must clear at once
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ack[ws%0d]", ws_of(i)), 32'(ack_s[i]), 32'h0);
      chk($sformatf("rst_busy[ws%0d]", ws_of(i)), 32'(busy_s[i]), 32'h0);
      chk($sformatf("rst_rdata[ws%0d]", ws_of(i)), rdata_s[i], 32'h0);
    end
    model_clear();
    idle_inputs();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) known[i][j] = 1'b0;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", 32'(ack_s[i]), 32'h0);
      chk("reset_busy", 32'(busy_s[i]), 32'h0);
      chk("reset_rdata", rdata_s[i], 32'h0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Basic write/readback with two wait states, then zero wait states
    txn(0, 1'b1, 31'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 31'h10, 32'h0);
    txn(1, 1'b1, 31'h4, 32'h12345678);
    txn(1, 1'b0, 31'h4, 32'h0);

    // Upper address bits and byte offset are ignored
    txn(0, 1'b1, 31'h404, 32'hA5A5A5A5);
    txn(0, 1'b0, 31'h7, 32'h0);

    // req held high: back-to-back reads, DONE-cycle req ignored
    req_s[0] = 1'b1; cmd_s[0] = 1'b0; addr_s[0] = 31'h10;
    req_s[1] = 1'b1; cmd_s[1] = 1'b0; addr_s[1] = 31'h4;
    for (int k = 0; k < 11; k++) step();
    idle_inputs();
    wait_idle(0);
    step();

    // Inputs altered and req dropped while a write is in flight
    req_s[0] = 1'b1; cmd_s[0] = 1'b1; addr_s[0] = 31'h30; wdata_s[0] = 32'hCAFEF00D;
    step();
    addr_s[0] = 31'h34; wdata_s[0] = 32'h0BADF00D; cmd_s[0] = 1'b0;
    step();
    req_s[0] = 1'b0; addr_s[0] = 31'h38; wdata_s[0] = 32'hFFFFFFFF;
    step();
    idle_inputs();
    wait_idle(0);
    step();
    txn(0, 1'b0, 31'h30, 32'h0);
    txn(0, 1'b0, 31'h34, 32'h0);

    // Reset during the WAIT of a write discards it
    txn(0, 1'b1, 31'h20, 32'h11111111);
    req_s[0] = 1'b1; cmd_s[0] = 1'b1; addr_s[0] = 31'h20; wdata_s[0] = 32'h22222222;
    step();
    idle_inputs();
    step();
    async_reset();
    step();
    txn(0, 1'b0, 31'h20, 32'h0);

    // Random traffic on both instances, one reset in the middle
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 2; i++) begin
        req_s[i]   = ($urandom_range(0, 2) != 0);
        cmd_s[i]   = 1'($urandom_range(0, 1));
        addr_s[i]  = ($urandom_range(0, 1) == 1) ? 31'($urandom) : 31'($urandom_range(0, 63));
        wdata_s[i] = $urandom;
      end
      if (k == 1000) async_reset();
      step();
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
